// File: rtl/branch_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : branch_cmp_pipe
// Purpose  : Two-stage pipelined branch / set-compare unit. Stage 1 forms
//            A-B and captures N/V/C/Z, mode and tag. Stage 2 resolves the
//            condition into a 1-bit result (or flags an illegal mode).
//            Valid/ready handshake on both sides, no skid buffer.
// Optional : BRCMP_STATS_EN adds a saturating taken_count output.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready, in_a, in_b, in_mode[2:0], in_tag
//            out_valid/out_ready, out_result, out_illegal, out_tag
//            taken_count (only with BRCMP_STATS_EN)
// Revision : 1.0  initial release
// ============================================================================
module branch_cmp_pipe #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_result,
    output logic               out_illegal,
    output logic [TAG_W-1:0]   out_tag
`ifdef BRCMP_STATS_EN
    ,
    output logic [COUNT_W-1:0] taken_count
`endif
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2) begin : g_bad_width
        $error("branch_cmp_pipe: WIDTH must be >= 2");
    end
    if (COUNT_W < 1) begin : g_bad_count
        $error("branch_cmp_pipe: COUNT_W must be >= 1");
    end

    localparam logic [2:0] MODE_EQ  = 3'b000;
    localparam logic [2:0] MODE_NE  = 3'b001;
    localparam logic [2:0] MODE_LT  = 3'b100;
    localparam logic [2:0] MODE_GE  = 3'b101;
    localparam logic [2:0] MODE_LTU = 3'b110;
    localparam logic [2:0] MODE_GEU = 3'b111;

    // ---------------- handshake ----------------
    logic s1_valid_q, s2_valid_q;
    logic s2_adv;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_adv;

    // ---------------- stage 1: flags ----------------
    // Extra top bit carries "no borrow" out of A + ~B + 1.
    logic [WIDTH:0] diff;
    logic           n_d, v_d, c_d, z_d;

    assign diff = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
    assign c_d  = diff[WIDTH];
    assign n_d  = diff[WIDTH-1];
    assign z_d  = (diff[WIDTH-1:0] == '0);
    assign v_d  = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (in_a[WIDTH-1] ^ diff[WIDTH-1]);

    logic             s1_n_q, s1_v_q, s1_c_q, s1_z_q;
    logic [2:0]       s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_n_q     <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_c_q     <= 1'b0;
            s1_z_q     <= 1'b0;
            s1_mode_q  <= 3'b000;
            s1_tag_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_n_q    <= n_d;
                s1_v_q    <= v_d;
                s1_c_q    <= c_d;
                s1_z_q    <= z_d;
                s1_mode_q <= in_mode;
                s1_tag_q  <= in_tag;
            end
        end
    end

    // ---------------- stage 2: resolve ----------------
    logic result_d, illegal_d;

    always_comb begin
        result_d  = 1'b0;
        illegal_d = 1'b0;
        case (s1_mode_q)
            MODE_EQ:  result_d = s1_z_q;
            MODE_NE:  result_d = ~s1_z_q;
            MODE_LT:  result_d = s1_n_q ^ s1_v_q;
            MODE_GE:  result_d = ~(s1_n_q ^ s1_v_q);
            MODE_LTU: result_d = ~s1_c_q;
            MODE_GEU: result_d = s1_c_q;
            default:  illegal_d = 1'b1;
        endcase
    end

    logic             s2_result_q, s2_illegal_q;
    logic [TAG_W-1:0] s2_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 1'b0;
            s2_illegal_q <= 1'b0;
            s2_tag_q     <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            // Only load real operations so the held outputs never pick up a bubble.
            if (s1_valid_q) begin
                s2_result_q  <= result_d;
                s2_illegal_q <= illegal_d;
                s2_tag_q     <= s1_tag_q;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_illegal = s2_illegal_q;
    assign out_tag     = s2_tag_q;

`ifdef BRCMP_STATS_EN
    // ---------------- optional taken counter ----------------
    logic [COUNT_W-1:0] taken_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_count_q <= '0;
        end else if (out_valid && out_ready && out_result && (taken_count_q != '1)) begin
            taken_count_q <= taken_count_q + 1'b1;
        end
    end

    assign taken_count = taken_count_q;
`endif

endmodule
`default_nettype wire
